// File: rtl/i2c_lcd_page_reader.sv
// i2c_lcd_page_reader: streams one 2x16 LCD page to the LCD writer.
// The page comes from the menu ROM or from one of two RAM pages. Each line
// starts with a cursor-position command, followed by 16 character bytes.
// Every character is fetched through the RAM controller, whose read data
// arrives one cycle after the address is presented.
module i2c_lcd_page_reader #(
    parameter logic [7:0] LINE1_CMD  = 8'h80,
    parameter logic [7:0] LINE2_CMD  = 8'hC0,
    parameter logic [7:0] FILL_CHAR  = 8'hFE,
    parameter logic [7:0] SPACE_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] page_sel,
    input  logic [3:0] line1_menu,
    input  logic [3:0] line2_menu,
    input  logic [7:0] MultiRAM_DOUT,
    output logic [1:0] MultiRAM_SEL,
    output logic [4:0] MultiRAM_ADD,
    output logic [3:0] MenuRAM_Select,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_valid,
    input  logic       lcd_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, CAPT, SEND, DONE} state_t;

    state_t     state;
    logic       line_bit;
    logic [3:0] col;
    logic [1:0] page;
    logic [3:0] menu_l1;
    logic [3:0] menu_l2;

    // The menu ROM is addressed by column only (its row comes from
    // MenuRAM_Select); the RAM pages use the line bit as the address MSB.
    function automatic logic [4:0] ram_addr(input logic [1:0] pg,
                                            input logic       kk,
                                            input logic [3:0] cc);
        ram_addr = (pg == 2'd0) ? {1'b0, cc} : {kk, cc};
    endfunction

    // Page sequencer: walks CMD -> (ADDR, CAPT, SEND) x16 per line and drives
    // every output from a register so the LCD writer and RAM see clean levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            line_bit       <= 1'b0;
            col            <= 4'd0;
            page           <= 2'd0;
            menu_l1        <= 4'd0;
            menu_l2        <= 4'd0;
            MultiRAM_SEL   <= 2'd0;
            MultiRAM_ADD   <= 5'd0;
            MenuRAM_Select <= 4'd0;
            lcd_data       <= 8'd0;
            lcd_rs         <= 1'b0;
            lcd_valid      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && page_sel != 2'd3) begin
                        page      <= page_sel;
                        menu_l1   <= line1_menu;
                        menu_l2   <= line2_menu;
                        line_bit  <= 1'b0;
                        col       <= 4'd0;
                        busy      <= 1'b1;
                        lcd_valid <= 1'b1;
                        lcd_rs    <= 1'b0;
                        lcd_data  <= LINE1_CMD;
                        state     <= CMD;
                    end
                end
                CMD: begin
                    if (lcd_ready) begin
                        lcd_valid      <= 1'b0;
                        MultiRAM_SEL   <= page;
                        MultiRAM_ADD   <= ram_addr(page, line_bit, col);
                        MenuRAM_Select <= line_bit ? menu_l2 : menu_l1;
                        state          <= ADDR;
                    end
                end
                ADDR: begin
                    state <= CAPT;
                end
                CAPT: begin
                    if (page == 2'd0 && MultiRAM_DOUT == FILL_CHAR) begin
                        lcd_data <= SPACE_CHAR;
                    end else begin
                        lcd_data <= MultiRAM_DOUT;
                    end
                    lcd_rs    <= 1'b1;
                    lcd_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (lcd_ready) begin
                        if (col != 4'd15) begin
                            col          <= col + 4'd1;
                            lcd_valid    <= 1'b0;
                            MultiRAM_ADD <= ram_addr(page, line_bit, col + 4'd1);
                            state        <= ADDR;
                        end else if (!line_bit) begin
                            col      <= 4'd0;
                            line_bit <= 1'b1;
                            lcd_rs   <= 1'b0;
                            lcd_data <= LINE2_CMD;
                            state    <= CMD;
                        end else begin
                            lcd_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_lcd_page_reader.sv
// tb_i2c_lcd_page_reader: scoreboard bench for the LCD page reader.
// Expected bytes are queued when a refresh is requested and matched in order
// against the bytes the LCD writer accepts.
module tb_i2c_lcd_page_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] page_sel;
    logic [3:0] line1_menu;
    logic [3:0] line2_menu;
    logic [7:0] MultiRAM_DOUT;
    logic [1:0] MultiRAM_SEL;
    logic [4:0] MultiRAM_ADD;
    logic [3:0] MenuRAM_Select;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_valid;
    logic       lcd_ready;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        logic [4:0] add;
        logic [3:0] menu;
    } xfer_t;

    xfer_t obs_q[$];
    xfer_t exp_q[$];
    xfer_t stall_q[$];

    i2c_lcd_page_reader dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .page_sel(page_sel),
        .line1_menu(line1_menu),
        .line2_menu(line2_menu),
        .MultiRAM_DOUT(MultiRAM_DOUT),
        .MultiRAM_SEL(MultiRAM_SEL),
        .MultiRAM_ADD(MultiRAM_ADD),
        .MenuRAM_Select(MenuRAM_Select),
        .lcd_data(lcd_data),
        .lcd_rs(lcd_rs),
        .lcd_valid(lcd_valid),
        .lcd_ready(lcd_ready),
        .busy(busy),
        .done(done)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Memory contents seen through the RAM controller: menu rows as text
    // padded with the fill code, remote page 0x61+addr with one fill code at
    // address 5, local page 0x41+addr.
    function automatic logic [7:0] ram_model(input logic [1:0] sel,
                                             input logic [4:0] add,
                                             input logic [3:0] row);
        logic [71:0] main_txt;
        logic [39:0] setup_txt;
        int          col;
        main_txt  = "MAIN MENU";
        setup_txt = "SETUP";
        col       = int'(add[3:0]);
        case (sel)
            2'd0: begin
                if (row == 4'd0) return (col < 9) ? main_txt[8*(8-col) +: 8] : 8'hFE;
                else if (row == 4'd3) return (col < 5) ? setup_txt[8*(4-col) +: 8] : 8'hFE;
                else return 8'h2A;
            end
            2'd1: return (add == 5'd5) ? 8'hFE : 8'h61 + {3'b000, add};
            2'd2: return 8'h41 + {3'b000, add};
            default: return 8'h00;
        endcase
    endfunction

    // Registered read port: data follows the address by one clock.
    always @(posedge clk) begin
        MultiRAM_DOUT <= ram_model(MultiRAM_SEL, MultiRAM_ADD, MenuRAM_Select);
    end

    // Requests one refresh and records every accepted byte. Optional features:
    // a stall of stall_len SEND cycles after the 7th transfer, a stray start
    // pulse at cycle restart_at, and an early exit after stop_after transfers.
    task automatic run_page(input logic [1:0] sel, input logic [3:0] l1, input logic [3:0] l2,
                            input int stall_len, input int restart_at, input int stop_after,
                            output int latency, output bit timed_out);
        bit   finished  = 1'b0;
        bit   seen_busy = 1'b0;
        int   busy_cyc  = 0;
        int   xfers     = 0;
        int   stalled   = 0;
        logic nr;
        latency = -1;
        obs_q.delete();
        stall_q.delete();
        @(posedge clk); #1;
        start      = 1'b1;
        page_sel   = sel;
        line1_menu = l1;
        line2_menu = l2;
        lcd_ready  = 1'b1;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            nr = lcd_ready;
            if (busy && !seen_busy) begin
                seen_busy = 1'b1;
                busy_cyc  = cyc;
            end
            if (lcd_valid && lcd_ready) begin
                obs_q.push_back('{lcd_rs, lcd_data, MultiRAM_ADD, MenuRAM_Select});
                xfers++;
                if (stall_len > 0 && xfers == 7) nr = 1'b0;
                if (stop_after > 0 && xfers == stop_after) finished = 1'b1;
            end else if (lcd_valid && !lcd_ready) begin
                stall_q.push_back('{lcd_rs, lcd_data, MultiRAM_ADD, MenuRAM_Select});
                stalled++;
                if (stalled >= stall_len) nr = 1'b1;
            end
            if (done && seen_busy) begin
                latency  = cyc - busy_cyc;
                finished = 1'b1;
            end
            @(posedge clk); #1;
            start     = (cyc + 1 == restart_at);
            lcd_ready = nr;
        end
        start     = 1'b0;
        lcd_ready = 1'b1;
        timed_out = !finished;
    endtask

    // Reset forces every output low immediately, even in the middle of a page.
    task automatic test_reset();
        int         lat;
        bit         to;
        logic [7:0] got[8];
        string      nm[8];
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_page(2'd2, 4'd5, 4'd9, 0, -1, 3, lat, to);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_pre_busy got=%0b expected=1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        got = '{8'(MultiRAM_SEL), 8'(MultiRAM_ADD), 8'(MenuRAM_Select), lcd_data,
                8'(lcd_rs), 8'(lcd_valid), 8'(busy), 8'(done)};
        nm  = '{"MultiRAM_SEL", "MultiRAM_ADD", "MenuRAM_Select", "lcd_data",
                "lcd_rs", "lcd_valid", "busy", "done"};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== 8'd0) begin
                failures++;
                $display("[TB] FAIL reset_%s got=%h expected=00", nm[i], got[i]);
            end
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    // Local page with the LCD always ready: full stream, latency, done pulse.
    task automatic test_local_page();
        int    lat, n, idx;
        bit    to;
        xfer_t o, e;
        exp_q.push_back('{1'b0, 8'h80, 5'd0, 4'd0});
        for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, 8'(65 + i), 5'(i), 4'd5});
        exp_q.push_back('{1'b0, 8'hC0, 5'd0, 4'd0});
        for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, 8'(81 + i), 5'(16 + i), 4'd9});
        run_page(2'd2, 4'd5, 4'd9, 0, -1, 0, lat, to);
        checks++;
        if (to) begin failures++; $display("[TB] FAIL local_timeout got=timeout expected=done"); end
        checks++;
        if (lat != 98) begin failures++; $display("[TB] FAIL local_latency got=%0d expected=98", lat); end
        n = obs_q.size();
        checks++;
        if (n != 34) begin failures++; $display("[TB] FAIL local_count got=%0d expected=34", n); end
        idx = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.rs !== e.rs || o.data !== e.data || (e.rs && (o.add !== e.add || o.menu !== e.menu))) begin
                failures++;
                $display("[TB] FAIL local_xfer%0d got rs=%0b data=%h add=%0d menu=%0d expected rs=%0b data=%h add=%0d menu=%0d",
                         idx, o.rs, o.data, o.add, o.menu, e.rs, e.data, e.add, e.menu);
            end
            idx++;
        end
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL local_done_pulse got done=%0b busy=%0b expected done=0 busy=0", done, busy);
        end
    endtask

    // Menu page: fill codes become spaces and the ROM row follows the line.
    task automatic test_menu_page();
        int         lat, n, idx;
        bit         to;
        xfer_t      o, e;
        logic [7:0] l1_txt[16];
        logic [7:0] l2_txt[16];
        l1_txt = '{8'h4D, 8'h41, 8'h49, 8'h4E, 8'h20, 8'h4D, 8'h45, 8'h4E,
                   8'h55, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
        l2_txt = '{8'h53, 8'h45, 8'h54, 8'h55, 8'h50, 8'h20, 8'h20, 8'h20,
                   8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
        exp_q.push_back('{1'b0, 8'h80, 5'd0, 4'd0});
        for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, l1_txt[i], 5'(i), 4'd0});
        exp_q.push_back('{1'b0, 8'hC0, 5'd0, 4'd0});
        for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, l2_txt[i], 5'(i), 4'd3});
        run_page(2'd0, 4'd0, 4'd3, 0, -1, 0, lat, to);
        checks++;
        if (to) begin failures++; $display("[TB] FAIL menu_timeout got=timeout expected=done"); end
        n = obs_q.size();
        checks++;
        if (n != 34) begin failures++; $display("[TB] FAIL menu_count got=%0d expected=34", n); end
        idx = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.rs !== e.rs || o.data !== e.data || (e.rs && (o.add !== e.add || o.menu !== e.menu))) begin
                failures++;
                $display("[TB] FAIL menu_xfer%0d got rs=%0b data=%h add=%0d menu=%0d expected rs=%0b data=%h add=%0d menu=%0d",
                         idx, o.rs, o.data, o.add, o.menu, e.rs, e.data, e.add, e.menu);
            end
            idx++;
        end
        exp_q.delete();
    endtask

    // Five not-ready cycles on line 1 column 6: outputs hold, latency grows by 5.
    task automatic test_backpressure();
        int    lat, n, idx;
        bit    to;
        xfer_t o, e;
        exp_q.push_back('{1'b0, 8'h80, 5'd0, 4'd0});
        for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, 8'(65 + i), 5'(i), 4'd1});
        exp_q.push_back('{1'b0, 8'hC0, 5'd0, 4'd0});
        for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, 8'(81 + i), 5'(16 + i), 4'd2});
        run_page(2'd2, 4'd1, 4'd2, 5, -1, 0, lat, to);
        checks++;
        if (to) begin failures++; $display("[TB] FAIL bp_timeout got=timeout expected=done"); end
        checks++;
        if (lat != 103) begin failures++; $display("[TB] FAIL bp_latency got=%0d expected=103", lat); end
        n = stall_q.size();
        checks++;
        if (n != 5) begin failures++; $display("[TB] FAIL bp_stall_cycles got=%0d expected=5", n); end
        for (int i = 0; i < stall_q.size(); i++) begin
            checks++;
            if (stall_q[i].rs !== 1'b1 || stall_q[i].data !== 8'h47 || stall_q[i].add !== 5'd6) begin
                failures++;
                $display("[TB] FAIL bp_hold%0d got rs=%0b data=%h add=%0d expected rs=1 data=47 add=6",
                         i, stall_q[i].rs, stall_q[i].data, stall_q[i].add);
            end
        end
        n = obs_q.size();
        checks++;
        if (n != 34) begin failures++; $display("[TB] FAIL bp_count got=%0d expected=34", n); end
        idx = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.rs !== e.rs || o.data !== e.data || (e.rs && (o.add !== e.add || o.menu !== e.menu))) begin
                failures++;
                $display("[TB] FAIL bp_xfer%0d got rs=%0b data=%h add=%0d menu=%0d expected rs=%0b data=%h add=%0d menu=%0d",
                         idx, o.rs, o.data, o.add, o.menu, e.rs, e.data, e.add, e.menu);
            end
            idx++;
        end
        exp_q.delete();
    endtask

    // Invalid page in IDLE and a stray start while busy must both be ignored.
    task automatic test_start_ignored();
        int lat, n, idx, bad;
        bit to;
        xfer_t o, e;
        @(posedge clk); #1;
        start    = 1'b1;
        page_sel = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        bad   = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy !== 1'b0 || lcd_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL invalid_page_busy got=%0d active cycles expected=0", bad); end
        exp_q.push_back('{1'b0, 8'h80, 5'd0, 4'd0});
        for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, 8'(65 + i), 5'(i), 4'd0});
        exp_q.push_back('{1'b0, 8'hC0, 5'd0, 4'd0});
        for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, 8'(81 + i), 5'(16 + i), 4'd0});
        run_page(2'd2, 4'd0, 4'd0, 0, 50, 0, lat, to);
        checks++;
        if (to) begin failures++; $display("[TB] FAIL busy_start_timeout got=timeout expected=done"); end
        checks++;
        if (lat != 98) begin failures++; $display("[TB] FAIL busy_start_latency got=%0d expected=98", lat); end
        n = obs_q.size();
        checks++;
        if (n != 34) begin failures++; $display("[TB] FAIL busy_start_count got=%0d expected=34", n); end
        idx = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.rs !== e.rs || o.data !== e.data || (e.rs && o.add !== e.add)) begin
                failures++;
                $display("[TB] FAIL busy_start_xfer%0d got rs=%0b data=%h add=%0d expected rs=%0b data=%h add=%0d",
                         idx, o.rs, o.data, o.add, e.rs, e.data, e.add);
            end
            idx++;
        end
        exp_q.delete();
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0 || lcd_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL busy_start_after got=%0d active cycles expected=0", bad); end
    endtask

    // Reset at line 2 column 4 abandons the page; the next page restarts cleanly.
    task automatic test_reset_resume();
        int    lat, n, idx;
        bit    to;
        xfer_t o, e;
        run_page(2'd2, 4'd0, 4'd0, 0, -1, 22, lat, to);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || lcd_valid !== 1'b0 || MultiRAM_ADD !== 5'd0) begin
            failures++;
            $display("[TB] FAIL resume_reset got busy=%0b valid=%0b add=%0d expected busy=0 valid=0 add=0",
                     busy, lcd_valid, MultiRAM_ADD);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.push_back('{1'b0, 8'h80, 5'd0, 4'd0});
        for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, (i == 5) ? 8'hFE : 8'(97 + i), 5'(i), 4'd0});
        exp_q.push_back('{1'b0, 8'hC0, 5'd0, 4'd0});
        for (int i = 0; i < 16; i++) exp_q.push_back('{1'b1, 8'(113 + i), 5'(16 + i), 4'd0});
        run_page(2'd1, 4'd0, 4'd0, 0, -1, 0, lat, to);
        checks++;
        if (to) begin failures++; $display("[TB] FAIL resume_timeout got=timeout expected=done"); end
        n = obs_q.size();
        checks++;
        if (n != 34) begin failures++; $display("[TB] FAIL resume_count got=%0d expected=34", n); end
        if (n >= 2) begin
            checks++;
            if (obs_q[0].rs !== 1'b0 || obs_q[0].data !== 8'h80 || obs_q[1].add !== 5'd0) begin
                failures++;
                $display("[TB] FAIL resume_first got rs=%0b data=%h add=%0d expected rs=0 data=80 add=0",
                         obs_q[0].rs, obs_q[0].data, obs_q[1].add);
            end
        end
        idx = 0;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.rs !== e.rs || o.data !== e.data || (e.rs && (o.add !== e.add || o.menu !== e.menu))) begin
                failures++;
                $display("[TB] FAIL resume_xfer%0d got rs=%0b data=%h add=%0d menu=%0d expected rs=%0b data=%h add=%0d menu=%0d",
                         idx, o.rs, o.data, o.add, o.menu, e.rs, e.data, e.add, e.menu);
            end
            idx++;
        end
        exp_q.delete();
    endtask

    // Runs every scenario in order and prints the one-line summary.
    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        page_sel   = 2'd0;
        line1_menu = 4'd0;
        line2_menu = 4'd0;
        lcd_ready  = 1'b1;
        $display("[TB] starting i2c_lcd_page_reader scenarios");
        test_reset();
        test_local_page();
        test_menu_page();
        test_backpressure();
        test_start_ignored();
        test_reset_resume();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
